// File: rtl/pipe_stage_skid.sv
// Pipeline register with a one-entry skid buffer between two valid/ready stages.
// Latency: one cycle from input transfer to output when the stage drains.
// Backpressure: in_ready drops only when both entries are held, so a stalled
//   downstream never loses the entry that was in flight.
//
// Ports:
//   clk, rst              single clock, synchronous active-high reset
//   flush                 drop every held entry this cycle
//   in_valid/in_ready     upstream handshake; in_ctrl, in_rd, in_data payload
//   out_valid/out_ready   downstream handshake; out_ctrl, out_rd, out_data payload
//   occupancy             number of entries held (0..2)
module pipe_stage_skid #(
  parameter int DATA_WIDTH = 32,
  parameter int CTRL_WIDTH = 8,
  parameter int WIDTH      = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic [WIDTH-1:0]      in_rd,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic [WIDTH-1:0]      out_rd,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [1:0]            occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t                state;

  logic                  main_valid;
  logic [CTRL_WIDTH-1:0] main_ctrl;
  logic [WIDTH-1:0]      main_rd;
  logic [DATA_WIDTH-1:0] main_data;

  logic                  skid_valid;
  logic [CTRL_WIDTH-1:0] skid_ctrl;
  logic [WIDTH-1:0]      skid_rd;
  logic [DATA_WIDTH-1:0] skid_data;

  logic                  in_xfer;
  logic                  out_xfer;

  // Ready looks only at our own state plus rst/flush, never at out_ready,
  // so there is no combinational path from downstream back to upstream.
  assign in_ready = (state != TWO) && !rst && !flush;
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = main_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= EMPTY;
      main_valid <= 1'b0;
      main_ctrl  <= '0;
      main_rd    <= '0;
      main_data  <= '0;
      skid_valid <= 1'b0;
      skid_ctrl  <= '0;
      skid_rd    <= '0;
      skid_data  <= '0;
    end else if (flush) begin
      // Data is left alone so out_data keeps showing the last payload.
      state      <= EMPTY;
      main_valid <= 1'b0;
      main_ctrl  <= '0;
      main_rd    <= '0;
      skid_valid <= 1'b0;
      skid_ctrl  <= '0;
      skid_rd    <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (in_xfer) begin
            main_valid <= 1'b1;
            main_ctrl  <= in_ctrl;
            main_rd    <= in_rd;
            main_data  <= in_data;
            state      <= ONE;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            // Pass-through: the new entry replaces the one leaving.
            main_ctrl <= in_ctrl;
            main_rd   <= in_rd;
            main_data <= in_data;
          end else if (in_xfer) begin
            // Downstream stalled while upstream already committed: park it.
            skid_valid <= 1'b1;
            skid_ctrl  <= in_ctrl;
            skid_rd    <= in_rd;
            skid_data  <= in_data;
            state      <= TWO;
          end else if (out_xfer) begin
            main_valid <= 1'b0;
            state      <= EMPTY;
          end
        end
        TWO: begin
          if (out_ready) begin
            main_ctrl  <= skid_ctrl;
            main_rd    <= skid_rd;
            main_data  <= skid_data;
            skid_valid <= 1'b0;
            state      <= ONE;
          end
        end
        default: begin
          state      <= EMPTY;
          main_valid <= 1'b0;
          skid_valid <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = main_valid;
  // A bubble must never carry write enables or a destination downstream.
  assign out_ctrl  = main_valid ? main_ctrl : '0;
  assign out_rd    = main_valid ? main_rd : '0;
  assign out_data  = main_data;
  assign occupancy = (state == TWO) ? 2'd2 : ((state == ONE) ? 2'd1 : 2'd0);

endmodule

// File: tb/tb_pipe_stage_skid.sv
module tb_pipe_stage_skid;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [7:0]  in_ctrl, out_ctrl;
  logic [4:0]  in_rd, out_rd;
  logic [31:0] in_data, out_data;
  logic [1:0]  occupancy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipe_stage_skid #(.DATA_WIDTH(32), .CTRL_WIDTH(8), .WIDTH(5)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_rd(in_rd), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_rd(out_rd), .out_data(out_data),
    .occupancy(occupancy)
  );

  // Reference: the stage behaves as a FIFO of depth two whose head is shown
  // on the outputs; out_data remembers the last head it ever showed.
  typedef struct packed {
    logic [7:0]  c;
    logic [4:0]  r;
    logic [31:0] d;
  } ent_t;

  ent_t        q[$];
  logic [31:0] last_data = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    logic [31:0] e_ctrl, e_rd;
    e_ctrl = (q.size() > 0) ? 32'(q[0].c) : 32'd0;
    e_rd   = (q.size() > 0) ? 32'(q[0].r) : 32'd0;
    chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
    chk("out_ctrl",  32'(out_ctrl),  e_ctrl);
    chk("out_rd",    32'(out_rd),    e_rd);
    chk("out_data",  out_data,       last_data);
    chk("occupancy", 32'(occupancy), 32'(q.size()));
    chk("in_ready",  32'(in_ready),  32'(q.size() < 2 && !rst && !flush));
    if (occupancy > 2'd2) chk("occ_max", 32'(occupancy), 32'd2);
  endtask

  task automatic model_step();
    bit out_fire, in_fire;
    ent_t e;
    if (rst) begin
      q.delete();
      last_data = 32'd0;
    end else if (flush) begin
      q.delete();
    end else begin
      out_fire = (q.size() > 0) && out_ready;
      in_fire  = in_valid && (q.size() < 2);
      if (out_fire) void'(q.pop_front());
      if (in_fire) begin
        e.c = in_ctrl; e.r = in_rd; e.d = in_data;
        q.push_back(e);
      end
    end
    if (q.size() > 0) last_data = q[0].d;
  endtask

  // One clock: drive at negedge, check before the edge, advance model at the edge.
  task automatic cycle(input logic r, input logic f, input logic iv, input logic ordy,
                       input logic [7:0] c, input logic [4:0] rd, input logic [31:0] d);
    rst = r; flush = f; in_valid = iv; out_ready = ordy;
    in_ctrl = c; in_rd = rd; in_data = d;
    #1;
    compare();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  logic [31:0] stream_vals [4];

  initial begin
    stream_vals[0] = 32'h10; stream_vals[1] = 32'h20;
    stream_vals[2] = 32'h30; stream_vals[3] = 32'h40;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_ctrl = 8'd0; in_rd = 5'd0; in_data = 32'd0;
    @(posedge clk);
    @(negedge clk);

    // Reset state
    cycle(1, 0, 0, 0, 8'h0, 5'd0, 32'h0);
    rst = 1'b0; #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_occupancy", 32'(occupancy), 32'd0);
    chk("rst_out_data",  out_data,       32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    @(negedge clk);

    // Streaming at full throughput
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 1, 1, 8'(i + 1), 5'(i + 1), stream_vals[i]);
      chk("stream_data", out_data, stream_vals[i]);
      chk("stream_occ",  32'(occupancy), 32'd1);
    end
    cycle(0, 0, 0, 1, 8'h0, 5'd0, 32'h0);
    chk("stream_drain", 32'(out_valid), 32'd0);

    // Backpressure
    cycle(0, 0, 1, 0, 8'h1, 5'd1, 32'hA);
    chk("bp_occ1", 32'(occupancy), 32'd1);
    cycle(0, 0, 1, 0, 8'h2, 5'd2, 32'hB);
    chk("bp_occ2", 32'(occupancy), 32'd2);
    chk("bp_data_a", out_data, 32'hA);
    cycle(0, 0, 1, 0, 8'h3, 5'd3, 32'hC);
    cycle(0, 0, 1, 1, 8'h3, 5'd3, 32'hC);
    chk("bp_data_b", out_data, 32'hB);
    cycle(0, 0, 1, 1, 8'h3, 5'd3, 32'hC);
    chk("bp_data_c", out_data, 32'hC);
    cycle(0, 0, 0, 1, 8'h0, 5'd0, 32'h0);

    // Flush while two entries are held
    cycle(0, 0, 1, 0, 8'h11, 5'd4, 32'h1);
    cycle(0, 0, 1, 0, 8'h12, 5'd5, 32'h2);
    cycle(0, 1, 1, 0, 8'h13, 5'd6, 32'h3);
    chk("flush_occ",  32'(occupancy), 32'd0);
    chk("flush_ctrl", 32'(out_ctrl),  32'd0);
    chk("flush_rd",   32'(out_rd),    32'd0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 8'h0, 5'd0, 32'h0);

    // Bubble after a single entry
    cycle(0, 0, 1, 1, 8'hFF, 5'd7, 32'h55);
    chk("bub_ctrl_live", 32'(out_ctrl), 32'hFF);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 8'h0, 5'd0, 32'h0);
    chk("bub_ctrl", 32'(out_ctrl), 32'd0);
    chk("bub_rd",   32'(out_rd),   32'd0);
    chk("bub_data", out_data,      32'h55);

    // Reset while two entries are held
    cycle(0, 0, 1, 0, 8'h21, 5'd8, 32'h77);
    cycle(0, 0, 1, 0, 8'h22, 5'd9, 32'h88);
    cycle(1, 0, 1, 1, 8'h23, 5'd10, 32'h99);
    chk("rst2_occ",  32'(occupancy), 32'd0);
    chk("rst2_data", out_data,       32'd0);
    chk("rst2_rdy",  32'(in_ready),  32'd0);
    cycle(0, 0, 0, 0, 8'h0, 5'd0, 32'h0);
    chk("rst2_rdy_after", 32'(in_ready), 32'd1);

    // Random traffic
    for (int i = 0; i < 10000; i++) begin
      cycle(($urandom_range(255) == 0),
            ($urandom_range(15) == 0),
            ($urandom_range(3) != 0),
            ($urandom_range(2) != 0),
            8'($urandom), 5'($urandom), $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
